i2c_txn_arbiter: RTL and testbench

- Sequences and shares the single I2C master core between NREQ requesters, e.g. the pH-sensor poller and the LCD writer.
- Round-robin arbitration; one transaction in flight at a time.
- Owns the core's start/rw/address/register/tx-data inputs and parks the core between transactions.
- Watches the core's done/ack outputs and returns per-requester responses, with a watchdog abort for hung transfers.

---
 rtl/i2c_arb_pkg.sv | 17 +
 rtl/i2c_txn_arbiter_rr_arbiter.sv | 39 +++
 rtl/i2c_txn_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the I2C transaction arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_RESP  = 3'd3,
        ST_ABORT = 3'd4
    } arb_state_e;

    localparam int ADDR_W    = 7;
    localparam int REG_W     = 8;
    localparam int DATA_W    = 8;
    localparam int MAX_RETRY = 2;

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W:0]   sum_s  [NREQ];
    logic [IDX_W-1:0] cand_s [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign sum_s[k]  = {1'b0, ptr_i} + (IDX_W+1)'(k);
        assign cand_s[k] = (sum_s[k] >= (IDX_W+1)'(NREQ)) ?
                           IDX_W'(sum_s[k] - (IDX_W+1)'(NREQ)) : sum_s[k][IDX_W-1:0];
    end

    // Scan from farthest to nearest so the candidate closest to the pointer wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[cand_s[k]]) begin
                gnt_o            = '0;
                gnt_o[cand_s[k]] = 1'b1;
                idx_o            = cand_s[k];
                any_o            = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master core between NREQ requesters, one transaction at a time.
// Optional NACK retry (up to MAX_RETRY extra attempts) under I2C_TXN_ARBITER_RETRY_EN.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int START_HOLD     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [8*NREQ-1:0]    req_reg,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_ack,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 i2c_start,
    output logic                 i2c_rw,
    output logic [ADDR_W-1:0]    i2c_slave_address,
    output logic [REG_W-1:0]     i2c_slave_reg,
    output logic [DATA_W-1:0]    i2c_tx_data,
    input  logic                 i2c_done,
    input  logic                 i2c_ack,
    input  logic [DATA_W-1:0]    i2c_rx_data
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(START_HOLD + 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d, gidx_q, gidx_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REG_W-1:0]    reg_q, reg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TO_W-1:0]     wdog_q, wdog_d;
    logic                ack_seen_q, ack_seen_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_ack_q, rsp_ack_d;
    logic                rsp_to_q, rsp_to_d;
`ifdef I2C_TXN_ARBITER_RETRY_EN
    logic [1:0]          retry_q, retry_d;
`endif

    logic [NREQ-1:0]     arb_gnt_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_any_s;
    logic                ack_now_s;
    logic [IDX_W-1:0]    ptr_next_s;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .any_o (arb_any_s)
    );

    // An ack on the done cycle itself still counts for this attempt.
    assign ack_now_s  = ack_seen_q | i2c_ack;
    assign ptr_next_s = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    // Next-state and datapath decode for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        gnt_d       = gnt_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        hold_d      = hold_q;
        wdog_d      = wdog_q;
        ack_seen_d  = ack_seen_q;
        start_d     = 1'b1;
        busy_d      = busy_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_ack_d   = rsp_ack_q;
        rsp_to_d    = rsp_to_q;
`ifdef I2C_TXN_ARBITER_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    gnt_d   = arb_gnt_s;
                    gidx_d  = arb_idx_s;
                    rw_d    = req_rw[arb_idx_s];
                    addr_d  = req_addr[int'(arb_idx_s) * ADDR_W +: ADDR_W];
                    reg_d   = req_reg[int'(arb_idx_s) * REG_W +: REG_W];
                    wdata_d = req_wdata[int'(arb_idx_s) * DATA_W +: DATA_W];
                    busy_d  = 1'b1;
                    hold_d  = '0;
`ifdef I2C_TXN_ARBITER_RETRY_EN
                    retry_d = 2'd0;
`endif
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hold_q == HOLD_W'(START_HOLD - 1)) begin
                    start_d    = 1'b0;
                    wdog_d     = '0;
                    ack_seen_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                start_d    = 1'b0;
                wdog_d     = wdog_q + TO_W'(1);
                ack_seen_d = ack_now_s;
                if (i2c_done) begin
                    start_d = 1'b1;
`ifdef I2C_TXN_ARBITER_RETRY_EN
                    if (!ack_now_s && (retry_q < 2'(MAX_RETRY))) begin
                        retry_d = retry_q + 2'd1;
                        hold_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        rsp_valid_d = gnt_q;
                        rsp_ack_d   = ack_now_s;
                        rsp_to_d    = 1'b0;
                        rsp_rdata_d = rw_q ? DATA_W'(0) : i2c_rx_data;
                        state_d     = ST_RESP;
                    end
`else
                    rsp_valid_d = gnt_q;
                    rsp_ack_d   = ack_now_s;
                    rsp_to_d    = 1'b0;
                    rsp_rdata_d = rw_q ? DATA_W'(0) : i2c_rx_data;
                    state_d     = ST_RESP;
`endif
                end else if (wdog_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Counting this cycle, the window has now lasted TIMEOUT_CYCLES.
                    start_d     = 1'b1;
                    rsp_valid_d = gnt_q;
                    rsp_ack_d   = 1'b0;
                    rsp_to_d    = 1'b1;
                    rsp_rdata_d = DATA_W'(0);
                    state_d     = ST_ABORT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RESP, ST_ABORT: begin
                busy_d  = 1'b0;
                ptr_d   = ptr_next_s;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset parks the core with start high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            gnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            hold_q      <= '0;
            wdog_q      <= '0;
            ack_seen_q  <= 1'b0;
            start_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_ack_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
`ifdef I2C_TXN_ARBITER_RETRY_EN
            retry_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            gnt_q       <= gnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            wdog_q      <= wdog_d;
            ack_seen_q  <= ack_seen_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_to_q    <= rsp_to_d;
`ifdef I2C_TXN_ARBITER_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_ack           = rsp_ack_q;
    assign rsp_timeout       = rsp_to_q;
    assign busy              = busy_q;
    assign i2c_start         = start_q;
    assign i2c_rw            = rw_q;
    assign i2c_slave_address = addr_q;
    assign i2c_slave_reg     = reg_q;
    assign i2c_tx_data       = wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter with a behavioural I2C core model.
module tb_i2c_txn_arbiter;

    localparam int NREQ = 2;
`ifdef I2C_TXN_ARBITER_RETRY_EN
    localparam int NACK_ATTEMPTS = 3;
`else
    localparam int NACK_ATTEMPTS = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rw;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_reg;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_ack;
    logic              rsp_timeout;
    logic              busy;
    logic              i2c_start;
    logic              i2c_rw;
    logic [6:0]        i2c_slave_address;
    logic [7:0]        i2c_slave_reg;
    logic [7:0]        i2c_tx_data;
    logic              i2c_done;
    logic              i2c_ack;
    logic [7:0]        i2c_rx_data;

    i2c_txn_arbiter #(.NREQ(NREQ), .START_HOLD(4), .TIMEOUT_CYCLES(1000), .TO_W(17)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_reg(req_reg), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack), .rsp_timeout(rsp_timeout),
        .busy(busy), .i2c_start(i2c_start), .i2c_rw(i2c_rw),
        .i2c_slave_address(i2c_slave_address), .i2c_slave_reg(i2c_slave_reg),
        .i2c_tx_data(i2c_tx_data), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
        .i2c_rx_data(i2c_rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       ack;
        logic       to;
        logic [7:0] rdata;
        int         attempts;
        int         run_len;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_ptr = 0;

    // core model state
    int         mdl_done_at = 0;
    int         mdl_ack_at  = 0;
    logic [7:0] mdl_rx      = 8'h00;
    int         run_cnt = 0, hi_cnt = 0, last_run = 0, last_gap = 0, attempts = 0;
    logic       cap_rw = 1'b0;
    logic [6:0] cap_addr = 7'h00;
    logic [7:0] cap_reg = 8'h00, cap_wd = 8'h00;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic set_ops(input int i, input logic rw, input logic [6:0] a,
                           input logic [7:0] r, input logic [7:0] w);
        req_rw[i]          = rw;
        req_addr[7*i +: 7] = a;
        req_reg[8*i +: 8]  = r;
        req_wdata[8*i +: 8] = w;
    endtask

    task automatic push_exp(input int i, input logic ack, input logic to, input logic [7:0] rd,
                            input int att, input int rl, input int gap);
        exp_t e;
        e.idx = i; e.rw = req_rw[i]; e.addr = req_addr[7*i +: 7];
        e.rg = req_reg[8*i +: 8]; e.wd = req_wdata[8*i +: 8];
        e.ack = ack; e.to = to; e.rdata = rd; e.attempts = att; e.run_len = rl; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic expect_rsp(input bit drop_req);
        exp_t e;
        logic [NREQ-1:0] onehot;
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        onehot = '0;
        onehot[e.idx] = 1'b1;
        check_val("rsp_valid", 64'(rsp_valid), 64'(onehot));
        check_val("rsp_ack", 64'(rsp_ack), 64'(e.ack));
        check_val("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        check_val("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check_val("busy_at_rsp", 64'(busy), 64'(1'b1));
        check_val("start_at_rsp", 64'(i2c_start), 64'(1'b1));
        check_val("operands", 64'({cap_rw, cap_addr, cap_reg, cap_wd}),
                  64'({e.rw, e.addr, e.rg, e.wd}));
        check_val("attempts", 64'(attempts), 64'(e.attempts));
        check_val("run_len", 64'(last_run), 64'(e.run_len));
        if (e.gap != 0) begin
            check_val("idle_gap", 64'(last_gap), 64'(e.gap));
        end else begin
            check_val("idle_gap_min", 64'(last_gap >= 6), 64'(1'b1));
        end
        if (drop_req) req = '0;
        exp_ptr = (e.idx + 1) % NREQ;
        attempts = 0;
        @(negedge clk); #1;
        check_val("after_rsp", 64'({rsp_valid, busy, i2c_start}), 64'({2'b00, 1'b0, 1'b1}));
    endtask

    task automatic check_reset_vals(input string tag);
        check_val(tag, 64'({rsp_valid, rsp_rdata, rsp_ack, rsp_timeout, busy, i2c_start,
                            i2c_rw, i2c_slave_address, i2c_slave_reg, i2c_tx_data}),
                  64'({2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 8'h00}));
    endtask

    // I2C core model: counts the start-low window, pulses ack/done at programmed cycles.
    initial begin
        i2c_done = 1'b0; i2c_ack = 1'b0; i2c_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack  = 1'b0;
            if (i2c_start) begin
                if (run_cnt != 0) last_run = run_cnt;
                run_cnt = 0;
                hi_cnt++;
            end else begin
                if (run_cnt == 0) begin
                    last_gap = hi_cnt;
                    hi_cnt = 0;
                    attempts++;
                    cap_rw = i2c_rw; cap_addr = i2c_slave_address;
                    cap_reg = i2c_slave_reg; cap_wd = i2c_tx_data;
                end
                run_cnt++;
                if (mdl_ack_at != 0 && run_cnt == mdl_ack_at) i2c_ack = 1'b1;
                if (mdl_done_at != 0 && run_cnt == mdl_done_at) begin
                    i2c_done = 1'b1;
                    i2c_rx_data = mdl_rx;
                end
            end
        end
    end

    initial begin
        int s0, n, seen;
        reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_reg = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset_state");
        reset = 1'b0;
        @(negedge clk); #1;
        check_reset_vals("idle_no_req");

        // single write from requester 0; write must return rdata 0
        set_ops(0, 1'b1, 7'h27, 8'h10, 8'hA5);
        mdl_done_at = 300; mdl_ack_at = 10; mdl_rx = 8'h77;
        push_exp(0, 1'b1, 1'b0, 8'h00, 1, 300, 0);
        req = 2'b01;
        expect_rsp(1'b1);

        // single read from requester 1
        set_ops(1, 1'b0, 7'h48, 8'h00, 8'h00);
        mdl_done_at = 250; mdl_ack_at = 10; mdl_rx = 8'h5C;
        push_exp(1, 1'b1, 1'b0, 8'h5C, 1, 250, 0);
        req = 2'b10;
        expect_rsp(1'b1);

        // contention: both held, grants alternate from the rr pointer
        set_ops(0, 1'b0, 7'h11, 8'h22, 8'h33);
        set_ops(1, 1'b1, 7'h44, 8'h55, 8'h66);
        mdl_done_at = 100; mdl_ack_at = 5; mdl_rx = 8'h9A;
        s0 = exp_ptr;
        for (int k = 0; k < 4; k++) begin
            int gi;
            gi = (s0 + k) % NREQ;
            push_exp(gi, 1'b1, 1'b0, (gi == 0) ? 8'h9A : 8'h00, 1, 100, (k == 0) ? 0 : 6);
        end
        req = 2'b11;
        for (int k = 0; k < 4; k++) expect_rsp(k == 3);

        // NACK: no ack ever; read data still captured
        set_ops(0, 1'b0, 7'h50, 8'h01, 8'h00);
        mdl_done_at = 120; mdl_ack_at = 0; mdl_rx = 8'h3C;
        push_exp(0, 1'b0, 1'b0, 8'h3C, NACK_ATTEMPTS, 120,
                 (NACK_ATTEMPTS > 1) ? 4 : 0);
        req = 2'b01;
        expect_rsp(1'b1);

        // timeout: done never arrives, ack seen must not leak into the response
        set_ops(1, 1'b1, 7'h3A, 8'h07, 8'hC3);
        mdl_done_at = 0; mdl_ack_at = 10; mdl_rx = 8'hFF;
        push_exp(1, 1'b0, 1'b1, 8'h00, 1, 1000, 0);
        req = 2'b10;
        expect_rsp(1'b1);

        // done on the very cycle the watchdog expires: completes normally
        set_ops(0, 1'b0, 7'h19, 8'h2B, 8'h00);
        mdl_done_at = 1000; mdl_ack_at = 10; mdl_rx = 8'hE1;
        push_exp(0, 1'b1, 1'b0, 8'hE1, 1, 1000, 0);
        req = 2'b01;
        expect_rsp(1'b1);

        // request withdrawn after grant still gets its response
        set_ops(1, 1'b0, 7'h62, 8'h0F, 8'h00);
        mdl_done_at = 200; mdl_ack_at = 10; mdl_rx = 8'h42;
        push_exp(1, 1'b1, 1'b0, 8'h42, 1, 200, 0);
        req = 2'b10;
        repeat (3) @(negedge clk);
        #1;
        req = '0;
        expect_rsp(1'b1);

        // reset at RUN cycle 500: no response, back to reset values
        set_ops(0, 1'b1, 7'h2D, 8'h80, 8'h5A);
        mdl_done_at = 800; mdl_ack_at = 10; mdl_rx = 8'h00;
        req = 2'b01;
        n = 0;
        while (run_cnt != 500 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("reached_run500", 64'(run_cnt), 64'(500));
        reset = 1'b1;
        req = '0;
        @(negedge clk); #1;
        check_reset_vals("reset_mid_run");
        reset = 1'b0;
        attempts = 0;
        exp_ptr = 0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (rsp_valid != '0 || i2c_start != 1'b1) seen++;
        end
        check_val("quiet_after_reset", 64'(seen), 64'(0));

        set_ops(1, 1'b0, 7'h33, 8'h44, 8'h00);
        mdl_done_at = 150; mdl_ack_at = 10; mdl_rx = 8'h18;
        push_exp(1, 1'b1, 1'b0, 8'h18, 1, 150, 0);
        req = 2'b10;
        expect_rsp(1'b1);

        check_val("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
